// File: rtl/dlx_pkg.sv
// ----------------------------------------------------------------------------
// dlx_pkg
// Shared definitions for the DLX single-cycle core support logic.
//   TRAP_HALT       : instruction encoding of the halt trap
//   DMEM_DUMP_START : first byte address of the data-memory dump window
//   DMEM_DUMP_END   : exclusive end byte address of the dump window
//   DUMP_CNT_W      : default width of the dumped-word counter
//   dump_state_t    : state encoding of the trap dump engine
// ----------------------------------------------------------------------------
package dlx_pkg;

    localparam logic [31:0] TRAP_HALT       = 32'h4400_0300;
    localparam logic [31:0] DMEM_DUMP_START = 32'h0000_2000;
    localparam logic [31:0] DMEM_DUMP_END   = 32'h0000_2100;
    localparam int          DUMP_CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } dump_state_t;

    // Words are 32 bits wide, so consecutive word addresses differ by 4.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/trap_dump_unit.sv
// ----------------------------------------------------------------------------
// trap_dump_unit
// Watches the fetched instruction for the halt trap, freezes the core and
// then streams the data-memory window [DUMP_START, DUMP_END) out one word
// at a time over a valid/ready interface.
//
// Ports:
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   instruction  : instruction currently fetched by the core
//   enable       : trap detection allowed when 1
//   halt         : stalls core PC/register/memory writes
//   mem_rd_en    : data-memory word read strobe
//   mem_addr     : byte address of the word being read
//   mem_rdata    : big-endian word, valid the cycle after mem_rd_en
//   dump_valid   : dump_addr/dump_data hold a word
//   dump_ready   : sink accepts the word
//   dump_addr    : address of the presented word
//   dump_data    : presented word
//   dump_count   : number of words accepted so far
//   done         : whole window transferred
// ----------------------------------------------------------------------------
module trap_dump_unit
    import dlx_pkg::*;
#(
    parameter logic [31:0] DUMP_START = DMEM_DUMP_START,
    parameter logic [31:0] DUMP_END   = DMEM_DUMP_END,
    parameter logic [31:0] TRAP_WORD  = TRAP_HALT,
    parameter int          CNT_W      = DUMP_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [0:31]      instruction,
    input  logic             enable,
    output logic             halt,
    output logic             mem_rd_en,
    output logic [0:31]      mem_addr,
    input  logic [0:31]      mem_rdata,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [0:31]      dump_addr,
    output logic [0:31]      dump_data,
    output logic [CNT_W-1:0] dump_count,
    output logic             done
);

    // An empty window skips the read loop entirely.
    localparam bit EMPTY_WINDOW = (DUMP_START == DUMP_END);

    dump_state_t state_q;
    dump_state_t state_d;

    logic [31:0] addr_cnt;
    logic [31:0] addr_next;
    logic        trap_hit;
    logic        accept;
    logic        last_word;

    assign trap_hit  = enable && (instruction == TRAP_WORD);
    assign accept    = (state_q == SEND) && dump_ready;
    assign addr_next = next_word_addr(addr_cnt);
    assign last_word = (addr_next == DUMP_END);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Once out of IDLE the trap input is ignored, so a
    // re-presented trap can never restart a dump in progress or a finished one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (trap_hit) begin
                    state_d = EMPTY_WINDOW ? DONE : READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: state_d = SEND;
            SEND: begin
                if (dump_ready) begin
                    state_d = last_word ? DONE : READ;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode straight from the current state.
    always_comb begin
        mem_rd_en  = 1'b0;
        dump_valid = 1'b0;
        done       = 1'b0;
        case (state_q)
            READ:    mem_rd_en  = 1'b1;
            SEND:    dump_valid = 1'b1;
            DONE:    done       = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr = addr_cnt;

    // halt is registered from the next state so it rises one edge after the
    // trap and stays high for the rest of the dump and in DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halt <= 1'b0;
        end else begin
            halt <= (state_d != IDLE);
        end
    end

    // Address counter: advances only after a word is accepted and more
    // words remain, so it points at the word being read or presented.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_cnt <= DUMP_START;
        end else if (accept && !last_word) begin
            addr_cnt <= addr_next;
        end
    end

    // Capture the memory word when it becomes valid; the pair stays frozen
    // through SEND however long the sink stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dump_addr <= '0;
            dump_data <= '0;
        end else if (state_q == WAIT) begin
            dump_addr <= addr_cnt;
            dump_data <= mem_rdata;
        end
    end

    // Count of words the sink has accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dump_count <= '0;
        end else if (accept) begin
            dump_count <= dump_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_trap_dump_unit.sv
// ----------------------------------------------------------------------------
// tb_trap_dump_unit
// Scoreboard bench for trap_dump_unit: a default-window instance attached to
// a small synchronous memory model, plus an empty-window instance.
// ----------------------------------------------------------------------------
module tb_trap_dump_unit;
    import dlx_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  count;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [0:31] instruction;
    logic        enable;
    logic        dump_ready;

    logic        halt, mem_rd_en, dump_valid, done;
    logic [0:31] mem_addr, mem_rdata, dump_addr, dump_data;
    logic [7:0]  dump_count;

    logic        z_halt, z_mem_rd_en, z_dump_valid, z_done;
    logic [0:31] z_mem_addr, z_dump_addr, z_dump_data;
    logic [0:31] z_mem_rdata = '0;
    logic [7:0]  z_dump_count;

    logic [31:0] mem [0:63];
    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    bit          everRdZ = 0;
    bit          everValidZ = 0;
    bit          held = 0;
    logic [31:0] heldAddr, heldData;

    always #5 clock = ~clock;

    trap_dump_unit dut (
        .clock(clock), .reset(reset), .instruction(instruction), .enable(enable),
        .halt(halt), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_count(dump_count), .done(done)
    );

    trap_dump_unit #(.DUMP_START(32'h2000), .DUMP_END(32'h2000)) dutZ (
        .clock(clock), .reset(reset), .instruction(instruction), .enable(enable),
        .halt(z_halt), .mem_rd_en(z_mem_rd_en), .mem_addr(z_mem_addr), .mem_rdata(z_mem_rdata),
        .dump_valid(z_dump_valid), .dump_ready(dump_ready), .dump_addr(z_dump_addr),
        .dump_data(z_dump_data), .dump_count(z_dump_count), .done(z_done)
    );

    // Synchronous data memory: word at 0x2000+k*4 holds 0xA5000000+k.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h2000;
        if (a >= 32'h2000 && a < 32'h2100) return mem[off[7:2]];
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clock) begin
        if (mem_rd_en) mem_rdata <= memWord(mem_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks that a
    // stalled word stays frozen.
    always @(negedge clock) begin
        exp_t e;
        #2;
        if (z_mem_rd_en) everRdZ = 1;
        if (z_dump_valid) everValidZ = 1;
        if (!reset) begin
            held = 0;
        end else if (dump_valid) begin
            checkOutput("rd_en_during_send", mem_rd_en, 0);
            if (dump_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got addr %h with empty scoreboard", dump_addr);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_addr", dump_addr, e.addr);
                    checkOutput("sb_data", dump_data, e.data);
                    checkOutput("sb_count", 32'(dump_count), 32'(e.count));
                end
                held = 0;
            end else if (held) begin
                checkOutput("stall_addr", dump_addr, heldAddr);
                checkOutput("stall_data", dump_data, heldData);
            end else begin
                held = 1;
                heldAddr = dump_addr;
                heldData = dump_data;
            end
        end
    end

    // Loads the scoreboard, presents one trap and checks first-word timing.
    task automatic applyStimulus();
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            e.addr  = 32'h2000 + k * 4;
            e.data  = 32'hA500_0000 + k;
            e.count = 8'(k);
            expQ.push_back(e);
        end
        @(negedge clock);
        instruction = TRAP_HALT;
        enable = 1;
        @(posedge clock); #1;
        checkOutput("halt_T+1", halt, 1);
        checkOutput("rd_en_T+1", mem_rd_en, 1);
        checkOutput("mem_addr_T+1", mem_addr, 32'h2000);
        checkOutput("z_done_T+1", z_done, 1);
        checkOutput("z_halt_T+1", z_halt, 1);
        @(negedge clock);
        instruction = 32'h0;
        @(posedge clock); #1;
        checkOutput("valid_T+2", dump_valid, 0);
        @(posedge clock); #1;
        checkOutput("valid_T+3", dump_valid, 1);
        checkOutput("first_addr", dump_addr, 32'h2000);
        checkOutput("first_data", dump_data, 32'hA500_0000);
    endtask

    task automatic waitDone();
        bit seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1;
                break;
            end
        end
        checkOutput("done_reached", 32'(seen), 1);
    endtask

    task automatic waitWord(input logic [31:0] a);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (dump_valid && dump_addr == a) begin
                seen = 1;
                break;
            end
        end
        checkOutput("word_reached", 32'(seen), 1);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_halt"}, halt, 0);
        checkOutput({tag, "_rd_en"}, mem_rd_en, 0);
        checkOutput({tag, "_valid"}, dump_valid, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_count"}, 32'(dump_count), 0);
        checkOutput({tag, "_dump_addr"}, dump_addr, 0);
        checkOutput({tag, "_dump_data"}, dump_data, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'h2000);
        checkOutput({tag, "_z_done"}, z_done, 0);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'hA500_0000 + k;
        reset = 0;
        instruction = 32'h0;
        enable = 0;
        dump_ready = 1;
        repeat (2) @(negedge clock);
        #1 checkIdle("reset");
        @(negedge clock);
        reset = 1;

        // Trap with enable low, then a near-miss encoding with enable high.
        instruction = TRAP_HALT;
        enable = 0;
        repeat (3) begin
            @(posedge clock); #1;
            checkOutput("no_en_halt", halt, 0);
            checkOutput("no_en_rd_en", mem_rd_en, 0);
        end
        @(negedge clock);
        instruction = 32'h4400_0301;
        enable = 1;
        repeat (3) begin
            @(posedge clock); #1;
            checkOutput("near_trap_halt", halt, 0);
            checkOutput("near_trap_rd_en", mem_rd_en, 0);
            checkOutput("near_trap_z_done", z_done, 0);
        end

        // Full dump with a 5-cycle stall on word 3 and a trap during SEND.
        applyStimulus();
        waitWord(32'h200C);
        dump_ready = 0;
        instruction = TRAP_HALT;
        repeat (5) begin
            @(posedge clock); #1;
            checkOutput("bp_valid", dump_valid, 1);
            checkOutput("bp_addr", dump_addr, 32'h200C);
            checkOutput("bp_data", dump_data, 32'hA500_0003);
            checkOutput("bp_rd_en", mem_rd_en, 0);
            checkOutput("bp_count", 32'(dump_count), 3);
        end
        @(negedge clock);
        dump_ready = 1;
        instruction = 32'h0;
        waitDone();
        instruction = TRAP_HALT;
        repeat (4) @(negedge clock);
        #1;
        checkOutput("done_count", 32'(dump_count), 64);
        checkOutput("done_halt", halt, 1);
        checkOutput("done_flag", done, 1);
        checkOutput("done_valid", dump_valid, 0);
        checkOutput("done_rd_en", mem_rd_en, 0);
        checkOutput("queue_drained", 32'(expQ.size()), 0);
        instruction = 32'h0;

        // Second dump aborted by reset while word 10 is presented.
        @(negedge clock);
        reset = 0;
        #1;
        @(negedge clock);
        reset = 1;
        applyStimulus();
        waitWord(32'h2028);
        dump_ready = 0;
        #1 reset = 0;
        #1;
        checkIdle("abort");
        expQ.delete();
        repeat (2) @(negedge clock);
        reset = 1;
        dump_ready = 1;
        repeat (3) begin
            @(posedge clock); #1;
            checkOutput("post_abort_halt", halt, 0);
            checkOutput("post_abort_mem_addr", mem_addr, 32'h2000);
        end

        // Restart from the beginning after the abort.
        applyStimulus();
        waitDone();
        #1;
        checkOutput("rerun_count", 32'(dump_count), 64);
        checkOutput("rerun_queue", 32'(expQ.size()), 0);

        // Empty-window instance never reads or presents anything.
        checkOutput("z_never_rd", 32'(everRdZ), 0);
        checkOutput("z_never_valid", 32'(everValidZ), 0);
        checkOutput("z_count", 32'(z_dump_count), 0);
        checkOutput("z_done_end", z_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_dump_unit.md
Name: trap_dump_unit

Overview:
- Hardware readout engine for the single-cycle core.
- Watches the fetched instruction for the halt trap (32'h44000300) and freezes the core.
- Then reads the data-memory window [DUMP_START, DUMP_END) one 32-bit word at a time and streams each address/word pair out over a valid/ready interface.
- Puts in RTL the end-of-program memory dump that software-side benches perform. It is the reading end of the program-load/run flow.

Parameters:
- DUMP_START, 32'h2000, first byte address dumped; word-aligned.
- DUMP_END, 32'h2100, exclusive end byte address; word-aligned, must be >= DUMP_START.
- TRAP_WORD, 32'h44000300, instruction encoding that triggers the dump.
- CNT_W, 8, width of dump_count; must hold (DUMP_END-DUMP_START)/4.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  [0:31]  instruction currently fetched by the core.
- enable  in  1  trap detection allowed when 1.
- halt  out  1  stalls core PC/register/memory writes.
- mem_rd_en  out  1  data-memory word read strobe.
- mem_addr  out  [0:31]  byte address of the word read.
- mem_rdata  in  [0:31]  big-endian word {mem[a],mem[a+1],mem[a+2],mem[a+3]}, valid the cycle after mem_rd_en.
- dump_valid  out  1  dump_addr/dump_data hold a word.
- dump_ready  in  1  sink accepts the word.
- dump_addr  out  [0:31]  address of the word presented.
- dump_data  out  [0:31]  word presented.
- dump_count  out  [CNT_W-1:0]  number of words accepted so far.
- done  out  1  whole window transferred.

Behaviour:
- Reset (async, reset==0) forces:
  - state IDLE, addr_cnt=DUMP_START, dump_count=0.
  - Outputs halt, mem_rd_en, dump_valid and done all 0.
  - dump_addr and dump_data 0; mem_addr=DUMP_START.
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - If enable && instruction==TRAP_WORD at edge T, the next state is READ, or DONE directly when DUMP_START==DUMP_END.
  - Otherwise stay in IDLE.
- halt is a registered output. It is 1 in every state except IDLE, so it rises at T+1 and stays high until reset.
- READ:
  - mem_rd_en=1 and mem_addr=addr_cnt, both combinational from the state.
  - Next state is WAIT.
- WAIT:
  - mem_rdata is valid.
  - At the edge, dump_data<=mem_rdata and dump_addr<=addr_cnt.
  - Next state is SEND.
- SEND:
  - dump_valid=1. dump_addr and dump_data stay stable while dump_ready==0; there is no timeout.
  - On an edge with dump_valid&&dump_ready:
    - dump_count+=1.
    - If addr_cnt+4==DUMP_END, the next state is DONE.
    - Otherwise addr_cnt+=4 and the next state is READ.
- DONE:
  - done=1 and halt=1; the unit is terminal until reset.
  - dump_valid=0 and dump_count holds its final value.
- mem_rd_en is 0 outside READ. mem_addr tracks addr_cnt in all states.
- Timing:
  - First word: trap seen at edge T, READ in cycle T+1, dump_valid high from T+3.
  - With dump_ready tied to 1, the steady rate is 1 word per 3 cycles.
- Address arithmetic:
  - 32-bit, step 4.
  - No wrap is possible given the parameter constraints, and none is checked at runtime.
- Trap or enable changes while the state is not IDLE are ignored; there is no re-trigger.
- dump_ready asserted while dump_valid==0 has no effect.
- Reset asserted mid-dump aborts immediately; no partial word is presented afterwards.
- Reset deasserting asynchronously is tolerated; the first edge after release evaluates IDLE.

Decomposition:
- Shared package dlx_pkg holds:
  - TRAP_HALT = 32'h44000300, used as the default for TRAP_WORD.
  - DMEM_DUMP_START and DMEM_DUMP_END.
  - dump_state_t enum {IDLE, READ, WAIT, SEND, DONE}, encoded in 3 bits.
- No sub-module is needed; the FSM, address counter and output registers live in one module.
- The trap comparator is a single equality and stays inline.

Test Plan:
- Default params, memory preloaded with word 0x2000+k*4 holding value 32'hA5000000+k, instruction=32'h44000300 at edge T, dump_ready=1 ->
  - halt=1 at T+1.
  - First handshake with dump_addr=0x2000 and dump_data=0xA5000000 at T+3.
  - 64 handshakes, the last at 0x20FC with 0xA500003F.
  - done=1 and dump_count=64 afterwards.
- Backpressure: dump_ready low for 5 cycles on word 3 -> dump_valid held, dump_addr=0x200C and dump_data unchanged, mem_rd_en stays 0, no skipped or duplicated words.
- enable=0 with a trap, or a non-trap instruction 32'h44000301 with enable=1 -> state stays IDLE, halt=0, mem_rd_en never asserts.
- Trap re-presented during SEND and during DONE -> no restart; dump_count continues 1..64 exactly once.
- reset driven low while in SEND of word 10 -> all outputs 0 asynchronously, before the next edge. After release, IDLE; a new trap restarts at 0x2000 with dump_count from 0.
- Instance with DUMP_START=DUMP_END=32'h2000 plus a trap -> DONE at T+1, halt=1, mem_rd_en and dump_valid never asserted, dump_count=0.
